// File: rtl/term_write_ctrl.sv
// Write-side controller for the VGA terminal text buffer: arbitrates UART and
// keyboard characters, tracks the cursor and sequences one-cell-per-cycle clears.
module term_write_ctrl #(
    parameter int         NUM_CHARS_X = 80,
    parameter int         NUM_CHARS_Y = 30,
    parameter int         ADDR_W      = 12,
    parameter logic [7:0] BLANK       = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [7:0]        a_char,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [7:0]        b_char,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy
);

    localparam int N     = NUM_CHARS_X * NUM_CHARS_Y;
    localparam int COL_W = $clog2(NUM_CHARS_X);
    localparam int ROW_W = $clog2(NUM_CHARS_Y);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_CHARS_X - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_CHARS_Y - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] X_ADDR    = ADDR_W'(NUM_CHARS_X);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_q;
    logic [ADDR_W-1:0] cursor_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              wrEn_q;
    logic [ADDR_W-1:0] wrAddr_q;
    logic [7:0]        wrData_q;
    logic              lastA_q;

    logic              grantA;
    logic              grantB;
    logic              accept;
    logic [7:0]        acChar;
    logic              doWrite_d;
    logic [ADDR_W-1:0] wrAddr_d;
    logic [7:0]        wrData_d;
    logic [ADDR_W-1:0] cursor_d;
    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;
    logic              overflow_d;

    // On a tie the source that did not win last time gets the grant.
    always_comb begin
        grantA  = a_valid && (!b_valid || !lastA_q);
        grantB  = b_valid && !grantA;
        a_ready = (state_q == IDLE) && !reset && grantA;
        b_ready = (state_q == IDLE) && !reset && grantB;
        accept  = a_ready || b_ready;
        acChar  = a_ready ? a_char : b_char;
    end

    always_comb begin
        doWrite_d  = 1'b0;
        wrAddr_d   = cursor_q;
        wrData_d   = acChar;
        cursor_d   = cursor_q;
        col_d      = col_q;
        row_d      = row_q;
        overflow_d = 1'b0;
        case (acChar)
            8'h0D, 8'h0A: begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    overflow_d = 1'b1;
                end else begin
                    row_d    = row_q + 1'b1;
                    cursor_d = cursor_q + X_ADDR - ADDR_W'(col_q);
                end
            end
            8'h08: begin
                if (cursor_q != '0) begin
                    doWrite_d = 1'b1;
                    wrAddr_d  = cursor_q - 1'b1;
                    wrData_d  = BLANK;
                    cursor_d  = cursor_q - 1'b1;
                    if (col_q == '0) begin
                        col_d = COL_LAST;
                        row_d = row_q - 1'b1;
                    end else begin
                        col_d = col_q - 1'b1;
                    end
                end
            end
            default: begin
                doWrite_d = 1'b1;
                // Non-printable codes show up as a dash so they remain visible.
                if (acChar < 8'h20 || acChar > 8'h7E) begin
                    wrData_d = 8'h2D;
                end
                cursor_d = cursor_q + 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        overflow_d = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        endcase
    end

    // A write that overflows the screen is still issued, then the clear wipes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR;
            clr_q    <= '0;
            cursor_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= BLANK;
            lastA_q  <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    wrEn_q   <= 1'b1;
                    wrAddr_q <= clr_q;
                    wrData_q <= BLANK;
                    clr_q    <= clr_q + 1'b1;
                    if (clr_q == ADDR_LAST) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    wrEn_q <= accept && doWrite_d;
                    if (accept && doWrite_d) begin
                        wrAddr_q <= wrAddr_d;
                        wrData_q <= wrData_d;
                    end
                    if (accept) begin
                        lastA_q <= a_ready;
                        if (overflow_d) begin
                            cursor_q <= '0;
                            col_q    <= '0;
                            row_q    <= '0;
                            clr_q    <= '0;
                            state_q  <= CLEAR;
                        end else begin
                            cursor_q <= cursor_d;
                            col_q    <= col_d;
                            row_q    <= row_d;
                        end
                    end
                end
            endcase
        end
    end

    assign wr_en   = wrEn_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;
    assign cursor  = cursor_q;
    assign busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_term_write_ctrl.sv
// Directed self-checking bench for term_write_ctrl on an 80x30 screen.
module tb_term_write_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [7:0]  a_char, b_char;
    logic        a_ready, b_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [11:0] cursor;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    term_write_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_char  (a_char),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_char  (b_char),
        .b_ready (b_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cursor  (cursor),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one character on a source and wait (bounded) for its acceptance edge.
    task automatic sendChar(input bit useB, input logic [7:0] c);
        int waitCycles = 0;
        if (useB) begin
            b_valid = 1'b1;
            b_char  = c;
        end else begin
            a_valid = 1'b1;
            a_char  = c;
        end
        #1;
        while (!(useB ? b_ready : a_ready) && waitCycles < 3000) begin
            @(posedge clk);
            #2;
            waitCycles++;
        end
        if (waitCycles >= 3000) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout: char %h never accepted, ready=0 want 1", c);
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_reset;
        int bad = 0;
        int badK = -1;
        logic [11:0] badAddr = '0;
        reset   = 1'b1;
        a_valid = 1'b1;
        a_char  = 8'h52;
        b_valid = 1'b1;
        b_char  = 8'h53;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ((a_ready | b_ready) !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got a=%b b=%b want 0/0", a_ready, b_ready);
        end
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 12'd0 || wr_data !== 8'h20) begin
            failures++;
            $display("[TB] FAIL reset_wr: got en=%b addr=%0d data=%h want 0/0/20", wr_en, wr_addr, wr_data);
        end
        checks++;
        if (busy !== 1'b1 || cursor !== 12'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got busy=%b cursor=%0d want 1/0", busy, cursor);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset   = 1'b0;
        for (int k = 0; k < 2400; k++) begin
            @(posedge clk);
            #1;
            if (wr_en !== 1'b1 || wr_addr !== 12'(k) || wr_data !== 8'h20) begin
                if (bad == 0) begin
                    badK    = k;
                    badAddr = wr_addr;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL init_clear: %0d bad cycles, first k=%0d addr=%0d want addr=k en=1 data=20", bad, badK, badAddr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || cursor !== 12'd0) begin
            failures++;
            $display("[TB] FAIL clear_done: got en=%b busy=%b cursor=%0d want 0/0/0", wr_en, busy, cursor);
        end
    endtask

    task automatic test_hi;
        sendChar(1'b0, 8'h48);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 8'h48 || cursor !== 12'd1) begin
            failures++;
            $display("[TB] FAIL hi_H: got en=%b addr=%0d data=%h cur=%0d want 1/0/48/1", wr_en, wr_addr, wr_data, cursor);
        end
        sendChar(1'b0, 8'h69);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd1 || wr_data !== 8'h69 || cursor !== 12'd2) begin
            failures++;
            $display("[TB] FAIL hi_i: got en=%b addr=%0d data=%h cur=%0d want 1/1/69/2", wr_en, wr_addr, wr_data, cursor);
        end
    endtask

    task automatic test_back_to_back;
        bit expA;
        // A single B char first so the next tie goes to A.
        sendChar(1'b1, 8'h78);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd2 || wr_data !== 8'h78) begin
            failures++;
            $display("[TB] FAIL b_only: got en=%b addr=%0d data=%h want 1/2/78", wr_en, wr_addr, wr_data);
        end
        a_valid = 1'b1;
        a_char  = 8'h61;
        b_valid = 1'b1;
        b_char  = 8'h62;
        for (int i = 0; i < 4; i++) begin
            expA = (i % 2 == 0);
            #1;
            checks++;
            if (a_ready !== expA || b_ready !== !expA) begin
                failures++;
                $display("[TB] FAIL rr_grant%0d: got a=%b b=%b want %b/%b", i, a_ready, b_ready, expA, !expA);
            end
            @(posedge clk);
            #1;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 12'(3 + i) || wr_data !== (expA ? 8'h61 : 8'h62)) begin
                failures++;
                $display("[TB] FAIL rr_write%0d: got en=%b addr=%0d data=%h want 1/%0d/%h", i, wr_en, wr_addr, wr_data, 3 + i, expA ? 8'h61 : 8'h62);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        checks++;
        if (cursor !== 12'd7) begin
            failures++;
            $display("[TB] FAIL rr_cursor: got %0d want 7", cursor);
        end
    endtask

    task automatic test_control;
        sendChar(1'b0, 8'h0D);
        repeat (5) sendChar(1'b0, 8'h63);
        checks++;
        if (cursor !== 12'd85) begin
            failures++;
            $display("[TB] FAIL setup85: got %0d want 85", cursor);
        end
        sendChar(1'b0, 8'h0D);
        checks++;
        if (wr_en !== 1'b0 || cursor !== 12'd160) begin
            failures++;
            $display("[TB] FAIL cr: got en=%b cursor=%0d want 0/160", wr_en, cursor);
        end
        sendChar(1'b1, 8'h08);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd159 || wr_data !== 8'h20 || cursor !== 12'd159) begin
            failures++;
            $display("[TB] FAIL bs_wrap: got en=%b addr=%0d data=%h cur=%0d want 1/159/20/159", wr_en, wr_addr, wr_data, cursor);
        end
        sendChar(1'b0, 8'h07);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd159 || wr_data !== 8'h2D || cursor !== 12'd160) begin
            failures++;
            $display("[TB] FAIL bell_dash: got en=%b addr=%0d data=%h cur=%0d want 1/159/2d/160", wr_en, wr_addr, wr_data, cursor);
        end
    endtask

    task automatic test_overflow;
        int bad = 0;
        int badK = -1;
        logic [11:0] badAddr = '0;
        repeat (27) sendChar(1'b0, 8'h0A);
        repeat (79) sendChar(1'b1, 8'h71);
        checks++;
        if (cursor !== 12'd2399) begin
            failures++;
            $display("[TB] FAIL setup2399: got %0d want 2399", cursor);
        end
        sendChar(1'b0, 8'h5A);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd2399 || wr_data !== 8'h5A || cursor !== 12'd0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_write: got en=%b addr=%0d data=%h cur=%0d busy=%b want 1/2399/5a/0/1", wr_en, wr_addr, wr_data, cursor, busy);
        end
        a_valid = 1'b1;
        a_char  = 8'h59;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (wr_en !== 1'b1 || wr_addr !== 12'(k) || wr_data !== 8'h20 || a_ready !== 1'b0) begin
                if (bad == 0) begin
                    badK    = k;
                    badAddr = wr_addr;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL full_clear: %0d bad cycles, first k=%0d addr=%0d want addr=k ready=0", bad, badK, badAddr);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0 || a_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset: got en=%b ready=%b busy=%b want 0/0/1", wr_en, a_ready, busy);
        end
        a_valid = 1'b0;
        reset   = 1'b0;
        bad     = 0;
        for (int k = 0; k < 2400; k++) begin
            @(posedge clk);
            #1;
            if (wr_en !== 1'b1 || wr_addr !== 12'(k) || wr_data !== 8'h20) begin
                if (bad == 0) begin
                    badK    = k;
                    badAddr = wr_addr;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL restart_clear: %0d bad cycles, first k=%0d addr=%0d want addr=k", bad, badK, badAddr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || cursor !== 12'd0 || wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL restart_done: got busy=%b cursor=%0d en=%b want 0/0/0", busy, cursor, wr_en);
        end
    endtask

    task automatic test_bs_zero;
        a_valid = 1'b1;
        a_char  = 8'h08;
        b_valid = 1'b1;
        b_char  = 8'h6B;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_tie: got a=%b b=%b want 1/0", a_ready, b_ready);
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || cursor !== 12'd0) begin
            failures++;
            $display("[TB] FAIL bs_zero: got en=%b cursor=%0d want 0/0", wr_en, cursor);
        end
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b_after: got a=%b b=%b want 0/1", a_ready, b_ready);
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 8'h6B || cursor !== 12'd1) begin
            failures++;
            $display("[TB] FAIL b_write: got en=%b addr=%0d data=%h cur=%0d want 1/0/6b/1", wr_en, wr_addr, wr_data, cursor);
        end
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_char  = 8'h00;
        b_char  = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_hi();
        test_back_to_back();
        test_control();
        test_overflow();
        test_bs_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/term_write_ctrl.md
# term_write_ctrl

Write-side controller for the character-cell text buffer of the VGA terminal. It arbitrates two character sources (UART receive path and keyboard path) with round-robin fairness over valid/ready handshakes. It interprets control characters, maintains the cursor, and issues single-cell writes to the text buffer's write port. It also sequences a one-cell-per-cycle screen clear after reset and whenever the screen fills, replacing any bulk-clear loop in the display datapath.

## Interface
- NUM_CHARS_X, 80, columns per screen
- NUM_CHARS_Y, 30, rows per screen
- ADDR_W, 12, text-buffer address width; must satisfy 2^ADDR_W >= NUM_CHARS_X*NUM_CHARS_Y
- BLANK, 8'h20, fill code written by clear and backspace
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- a_valid / a_char  in  1 / 8  source A (UART) request and character
- a_ready  out  1  source A accepted this cycle
- b_valid / b_char  in  1 / 8  source B (keyboard) request and character
- b_ready  out  1  source B accepted this cycle
- wr_en  out  1  text-buffer write strobe, registered
- wr_addr  out  ADDR_W  cell address, registered
- wr_data  out  8  cell code, registered
- cursor  out  ADDR_W  next cell to be written (row*NUM_CHARS_X+col)
- busy  out  1  high while in CLEAR

## Operation
- Let N = NUM_CHARS_X*NUM_CHARS_Y. Cursor is held as separate col and row counters plus a linear address; no divider or multiplier.
- States: CLEAR, IDLE.
- CLEAR: each cycle registers wr_en=1, wr_addr=clr_addr, wr_data=BLANK, then clr_addr+1. The cycle that registers address N-1 moves to IDLE. a_ready=b_ready=0.
- IDLE arbitration is combinational: if exactly one valid, grant it. If both are valid, grant the source not granted last. Set x_ready=1 for the granted source only. Acceptance = valid & ready at a clock edge.
- Actions on acceptance of character c:
  - 0x20..0x7E: write c at cursor; col+1; if col was X-1, col=0 and row+1.
  - 0x0D or 0x0A: no write; col=0, row+1.
  - 0x08 (backspace): if cursor>0, write BLANK at cursor-1 and step back one cell, wrapping to col X-1 of the previous row. At cursor 0 it is a no-op with no write.
  - Any other code: write '-' (0x2D) and advance as printable.
- Screen full: if an advance would set row=Y (including CR/LF on the last row), the pending write (if any) is still issued. Cursor becomes 0, clr_addr=0, and the state goes to CLEAR.
- When no acceptance occurs, wr_en=0; wr_addr and wr_data hold their values.

## Timing
- Reset values: state=CLEAR, clr_addr=0, cursor=0, wr_en=0, wr_addr=0, wr_data=BLANK, a_ready=b_ready=0, busy=1, last grant=B (so A wins the first tie).
- After reset deassertion, the first clear write appears in cycle 1 and the last (address N-1) in cycle N. IDLE and ready are possible from cycle N+1.
- Write latency: character accepted at edge t; wr_en/wr_addr/wr_data valid during the cycle after t. cursor updates at edge t.
- Throughput: one accepted character per cycle in IDLE, with no bubbles between accepted characters.
- Overflow to CLEAR at edge t: the final character write is visible in cycle t+1; clear writes of addresses 0..N-1 occupy cycles t+2..t+N+1 (the char is immediately erased by design).
- reset asserted at any time, including mid-CLEAR or with valids high, restarts the clear from address 0 on the next edge; no ready is issued while reset is high.
- Sources must hold valid and char stable until ready; ready never asserts without valid.

## Test plan
- Reset, then idle: wr_en high for exactly 2400 consecutive cycles with addresses 0..2399 and data 0x20. busy falls at cycle 2401; cursor=0.
- A sends "Hi": writes (0,0x48) then (1,0x69) on consecutive cycles; cursor=2.
- A and B both hold valid for 4 cycles: grants alternate A,B,A,B and each ready is a single-cycle pulse per accepted char.
- Cursor=85, send 0x0D: no write, cursor=160. Then send 0x08: write (159,0x20), cursor=159. At cursor 0, 0x08 produces no write and cursor stays 0.
- Cursor=2399, send 'Z': write (2399,0x5A), then a 2400-cycle clear from address 0, cursor=0, ready low throughout. Assert reset at clear cycle 100: clear restarts at address 0.
- Send 0x07: write (cursor,0x2D) and cursor advances by 1.
